// File: rtl/dsp_accum_pkg.sv
// Shared types and the round/saturate helper for the MAC frame-drain stage.
// No latency (types and a pure function only).
// No backpressure (no handshake lives here).
package dsp_accum_pkg;

  localparam int ACC_W = 38;
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ACCUM   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic                    sat;
    logic signed [RES_W-1:0] data;
  } res_t;

  // Round-half-up then clip to out_w signed bits; one guard bit keeps the
  // rounding add from wrapping at the top of the accumulator range.
  function automatic res_t round_sat(input logic signed [ACC_W-1:0] p,
                                     input int shift,
                                     input int out_w);
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    res_t                  res;
    one = {{ACC_W{1'b0}}, 1'b1};
    s   = {p[ACC_W-1], p};
    if (shift > 0) begin
      s = s + (one <<< (shift - 1));
    end
    r  = s >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -(one <<< (out_w - 1));
    res.sat  = 1'b0;
    res.data = r[RES_W-1:0];
    if (r > hi) begin
      res.sat  = 1'b1;
      res.data = hi[RES_W-1:0];
    end else if (r < lo) begin
      res.sat  = 1'b1;
      res.data = lo[RES_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_result_fifo2.sv
// Two-entry result FIFO with a registered head entry and a sticky drop flag.
// Latency: a push is visible at rd_dat/rd_vld after the same negedge.
// Backpressure: no write-side ready; a push into a full FIFO without a pop is dropped.
module dsp_result_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         drop
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign rd_vld = (cnt_q != 2'd0);
  assign rd_dat = head_q;
  assign pop    = rd_vld & rd_rdy;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      drop   <= 1'b0;
    end else begin
      case ({wr_vld, pop})
        2'b10: begin
          case (cnt_q)
            2'd0: begin
              head_q <= wr_dat;
              cnt_q  <= 2'd1;
            end
            2'd1: begin
              tail_q <= wr_dat;
              cnt_q  <= 2'd2;
            end
            default: drop <= 1'b1;
          endcase
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy is unchanged, head advances.
          if (cnt_q == 2'd1) begin
            head_q <= wr_dat;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dsp_accum_frame_drain.sv
// Frames FRAME_LEN MAC accumulates, then rounds/saturates P and queues it.
// Latency: result valid one cycle after the CAPTURE cycle; frame = FRAME_LEN accepts + 2.
// Backpressure: in_ready_o only in ACCUM; a full output buffer drops results and sets overflow_o.
module dsp_accum_frame_drain #(
  parameter int ACC_W     = dsp_accum_pkg::ACC_W,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ACC_W-1:0] mac_p_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    mac_clear_o,
  output logic        [OUT_W-1:0] dout_o,
  output logic                    dout_sat_o,
  output logic                    dout_valid_o,
  input  logic                    dout_ready_i,
  output logic                    overflow_o
);

  import dsp_accum_pkg::*;

  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  state_t       state;
  logic [7:0]   cnt;
  res_t         rs;
  logic         push;
  logic [OUT_W:0] fifo_dat;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLEAR;
      cnt         <= '0;
      mac_clear_o <= 1'b1;
      in_ready_o  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          state       <= ACCUM;
          mac_clear_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
        ACCUM: begin
          if (in_valid_i && in_ready_o) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              state      <= CAPTURE;
              in_ready_o <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        CAPTURE: begin
          // P now holds the complete frame sum; clear the MAC next.
          state       <= CLEAR;
          mac_clear_o <= 1'b1;
        end
        default: begin
          state       <= CLEAR;
          cnt         <= '0;
          mac_clear_o <= 1'b1;
          in_ready_o  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rs   = round_sat(mac_p_i, SHIFT, OUT_W);
    push = (state == CAPTURE);
  end

  dsp_result_fifo2 #(.W(OUT_W + 1)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_dat ({rs.sat, rs.data[OUT_W-1:0]}),
    .rd_vld (dout_valid_o),
    .rd_rdy (dout_ready_i),
    .rd_dat (fifo_dat),
    .drop   (overflow_o)
  );

  assign dout_sat_o = fifo_dat[OUT_W];
  assign dout_o     = fifo_dat[OUT_W-1:0];

endmodule

// File: tb/tb_dsp_accum_frame_drain.sv
// Scoreboard bench: a negedge MAC model feeds the drain stage; a monitor checks each popped result.
module tb_dsp_accum_frame_drain;

  localparam int FL = 4;

  typedef struct packed {
    logic        sat;
    logic [15:0] d;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [37:0] mac_p = '0;
  logic signed [37:0] prod;
  logic signed [19:0] mac_a;
  logic signed [17:0] mac_b;
  logic               mac_sub;
  logic               in_valid;
  logic               in_ready;
  logic               mac_clear;
  logic [15:0]        dout;
  logic               dout_sat;
  logic               dout_valid;
  logic               dout_ready;
  logic               overflow;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   stall_en = 1'b0;
  exp_t exp_q[$];
  logic signed [19:0] va[FL];
  logic signed [17:0] vb[FL];

  always #5 clk = ~clk;

  dsp_accum_frame_drain #(
    .ACC_W(38), .OUT_W(16), .SHIFT(4), .FRAME_LEN(FL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mac_p_i      (mac_p),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .mac_clear_o  (mac_clear),
    .dout_o       (dout),
    .dout_sat_o   (dout_sat),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .overflow_o   (overflow)
  );

  // Signed 20x18 MAC with synchronous active-high clear, same clock edge as the DUT.
  assign prod = 38'(mac_a) * 38'(mac_b);
  always @(negedge clk) begin
    if (mac_clear) mac_p <= '0;
    else if (in_valid && in_ready) mac_p <= mac_sub ? mac_p - prod : mac_p + prod;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_rs(input longint p);
    longint r;
    exp_t   e;
    r = (p + 64'sd8) >>> 4;
    if (r > 64'sd32767) e = {1'b1, 16'h7fff};
    else if (r < -64'sd32768) e = {1'b1, 16'h8000};
    else e = {1'b0, 16'(r)};
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (stall_en) dout_ready = (cyc % 3) != 0;
  end

  // Monitor: a pop happens at the next negedge whenever valid and ready are both high.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got sat=%0b dout=%0d, expected no output", dout_sat, $signed(dout));
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'({dout_sat, dout}), 32'(e));
      end
    end
  end

  task automatic set_ab(input int a, input int b);
    for (int i = 0; i < FL; i++) begin
      va[i] = 20'(a);
      vb[i] = 18'(b);
    end
  endtask

  task automatic feed(input int npairs, input logic sub_m, output longint sum);
    int got = 0;
    int guard = 0;
    sum = 0;
    mac_sub = sub_m;
    @(posedge clk);
    while (got < npairs && guard < 100) begin
      in_valid = 1'b1;
      mac_a = va[got];
      mac_b = vb[got];
      if (in_ready) begin
        if (sub_m) sum = sum - longint'(va[got]) * longint'(vb[got]);
        else       sum = sum + longint'(va[got]) * longint'(vb[got]);
        got++;
      end
      @(posedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (got < npairs) begin
      n_vec++;
      n_err++;
      $display("FAIL feed_timeout: got %0d pairs accepted, expected %0d", got, npairs);
    end
  endtask

  task automatic frame(input logic sub_m, input bit keep, input bit use_ref, input exp_t hand);
    longint sum;
    feed(FL, sub_m, sum);
    if (keep) exp_q.push_back(use_ref ? ref_rs(sum) : hand);
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    check({name, "_valid_after_drain"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish within time budget");
    $fatal(1);
  end

  initial begin
    longint part;
    in_valid = 1'b0;
    dout_ready = 1'b1;
    mac_a = '0;
    mac_b = '0;
    mac_sub = 1'b0;

    // Reset state and the first CLEAR pulse
    repeat (2) @(posedge clk);
    #1;
    check("rst_mac_clear", 32'(mac_clear), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dout", 32'({dout_sat, dout}), 32'd0);
    @(posedge clk);
    reset = 1'b1;
    check("first_clear", 32'(mac_clear), 32'd1);
    @(posedge clk);
    check("clear_done", 32'(mac_clear), 32'd0);
    check("ready_open", 32'(in_ready), 32'd1);

    // Add frame with output latency checks: P=40 -> 3
    set_ab(5, 2);
    feed(FL, 1'b0, part);
    exp_q.push_back({1'b0, 16'd3});
    check("capture_in_ready", 32'(in_ready), 32'd0);
    check("capture_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    check("valid_after_capture", 32'(dout_valid), 32'd1);
    check("clear_after_capture", 32'(mac_clear), 32'd1);

    // Subtract frame: P=-40 -> -2
    set_ab(5, 2);
    frame(1'b1, 1'b1, 1'b0, {1'b0, 16'hfffe});
    // Saturation both ways: P=+/-2^30
    set_ab(16384, 16384);
    frame(1'b0, 1'b1, 1'b0, {1'b1, 16'h7fff});
    frame(1'b1, 1'b1, 1'b0, {1'b1, 16'h8000});
    wait_drain("directed");

    // Full buffer: results 3 and 6 held, 9 dropped
    dout_ready = 1'b0;
    set_ab(3, 4);
    frame(1'b0, 1'b1, 1'b0, {1'b0, 16'd3});
    set_ab(6, 4);
    frame(1'b0, 1'b1, 1'b0, {1'b0, 16'd6});
    set_ab(9, 4);
    frame(1'b0, 1'b0, 1'b0, {1'b0, 16'd9});
    repeat (2) @(posedge clk);
    check("overflow_set", 32'(overflow), 32'd1);
    check("full_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    wait_drain("overflow");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame with a result still buffered
    dout_ready = 1'b0;
    set_ab(3, 4);
    frame(1'b0, 1'b0, 1'b0, {1'b0, 16'd3});
    set_ab(5, 2);
    feed(2, 1'b0, part);
    check("pre_reset_valid", 32'(dout_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_mac_clear", 32'(mac_clear), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_dout", 32'({dout_sat, dout}), 32'd0);
    repeat (2) @(posedge clk);
    reset = 1'b1;
    dout_ready = 1'b1;
    set_ab(5, 2);
    frame(1'b0, 1'b1, 1'b0, {1'b0, 16'd3});
    wait_drain("post_reset");

    // Random frames in both modes against the reference model, with periodic consumer stalls
    stall_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < FL; k++) begin
        if ((i % 4) < 2) begin
          va[k] = 20'(int'($urandom_range(0, 600)) - 300);
          vb[k] = 18'(int'($urandom_range(0, 600)) - 300);
        end else begin
          va[k] = 20'(int'($urandom_range(0, 65535)) - 32768);
          vb[k] = 18'(int'($urandom_range(0, 262143)) - 131072);
        end
      end
      frame(1'(i % 2), 1'b1, 1'b1, '0);
    end
    stall_en = 1'b0;
    dout_ready = 1'b1;
    wait_drain("random");
    check("random_no_overflow", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
